// File: rtl/lif_sched_pkg.sv
// Shared types, constants and helpers for the LIF spike scheduler.
// Holds the reset weight table, the grant-index width and a saturating adder.
package lif_sched_pkg;

    localparam int ID_W                = 3;
    localparam int NUM_DEFAULT_WEIGHTS = 3;

    localparam logic [7:0] DEFAULT_WEIGHTS [NUM_DEFAULT_WEIGHTS] = '{8'd5, 8'd4, 8'd3};

    // Reset weight for a given input index; indices past the table load zero.
    function automatic logic [7:0] default_weight(input int idx);
        case (idx)
            0:       return DEFAULT_WEIGHTS[0];
            1:       return DEFAULT_WEIGHTS[1];
            2:       return DEFAULT_WEIGHTS[2];
            default: return 8'd0;
        endcase
    endfunction

    // a + b clamped to 2^width-1 (width <= 16).
    function automatic logic [15:0] sat_add(input logic [15:0] a,
                                            input logic [15:0] b,
                                            input int          width);
        logic [16:0] sum;
        logic [16:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (17'd1 << width) - 17'd1;
        if (sum > lim) begin
            return lim[15:0];
        end else begin
            return sum[15:0];
        end
    endfunction

endpackage

// File: rtl/lif_rr_arbiter.sv
// Combinational round-robin pick over the pending flags, starting at rr_ptr
// and searching upward with wrap-around.
module lif_rr_arbiter #(
    parameter int N    = 3,
    parameter int ID_W = 3
) (
    input  logic [N-1:0]    pending,
    input  logic [ID_W-1:0] rr_ptr,
    output logic            found,
    output logic [ID_W-1:0] winner
);

    logic            found_hi_s;
    logic            found_lo_s;
    logic            hit_hi_s;
    logic [ID_W-1:0] win_hi_s;
    logic [ID_W-1:0] win_lo_s;

    // Descending scan so the lowest qualifying index is the last one kept.
    always_comb begin
        found_hi_s = 1'b0;
        found_lo_s = 1'b0;
        hit_hi_s   = 1'b0;
        win_hi_s   = {ID_W{1'b0}};
        win_lo_s   = {ID_W{1'b0}};
        for (int j = N - 1; j >= 0; j--) begin
            hit_hi_s   = pending[j] && (ID_W'(j) >= rr_ptr);
            win_hi_s   = hit_hi_s ? ID_W'(j) : win_hi_s;
            found_hi_s = found_hi_s | hit_hi_s;
            win_lo_s   = pending[j] ? ID_W'(j) : win_lo_s;
            found_lo_s = found_lo_s | pending[j];
        end
        found  = found_hi_s | found_lo_s;
        winner = found_hi_s ? win_hi_s : win_lo_s;
    end

endmodule

// File: rtl/lif_spike_scheduler.sv
// Round-robin spike scheduler feeding one shared weighted-current accumulator.
// Define SCHED_DROP_CNT_EN to add the saturating drop_count output.
module lif_spike_scheduler
    import lif_sched_pkg::*;
#(
    parameter int N_INPUTS    = 3,
    parameter int W_WIDTH     = 4,
    parameter int CUR_WIDTH   = 4,
    parameter int ACC_WIDTH   = 8,
    parameter int TICK_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_INPUTS-1:0]  spike_in,
    input  logic                 cfg_we,
    input  logic [ID_W-1:0]      cfg_addr,
    input  logic [W_WIDTH-1:0]   cfg_wdata,
    output logic                 grant_valid,
    output logic [ID_W-1:0]      grant_id,
    output logic [CUR_WIDTH-1:0] current_out,
    output logic                 current_valid,
    output logic                 busy
`ifdef SCHED_DROP_CNT_EN
    ,
    output logic [7:0]           drop_count
`endif
);

    localparam int TICK_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [ACC_WIDTH-1:0] CUR_MAX = ACC_WIDTH'((1 << CUR_WIDTH) - 1);

    logic [N_INPUTS-1:0]  pending_q, pending_d;
    logic [N_INPUTS-1:0]  gnt_mask_s;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]      grant_id_q, grant_id_d;
    logic                 grant_valid_q, grant_valid_d;
    logic [ID_W-1:0]      winner_s;
    logic                 found_s;
    logic [W_WIDTH-1:0]   weight_q [N_INPUTS];
    logic [W_WIDTH-1:0]   weight_d [N_INPUTS];
    logic [W_WIDTH-1:0]   gnt_weight_s;
    logic [ACC_WIDTH-1:0] acc_q, acc_d, acc_grant_s;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic                 tick_last_s;
    logic [CUR_WIDTH-1:0] current_out_q, current_out_d;
    logic                 current_valid_q, current_valid_d;

    lif_rr_arbiter #(
        .N    (N_INPUTS),
        .ID_W (ID_W)
    ) u_arb (
        .pending (pending_q),
        .rr_ptr  (rr_ptr_q),
        .found   (found_s),
        .winner  (winner_s)
    );

    // Grant decode, pending update, pointer advance and weight writes.
    always_comb begin
        gnt_weight_s = {W_WIDTH{1'b0}};
        for (int j = 0; j < N_INPUTS; j++) begin
            gnt_mask_s[j] = found_s && (winner_s == ID_W'(j));
            gnt_weight_s  = gnt_weight_s | (weight_q[j] & {W_WIDTH{gnt_mask_s[j]}});
            // The grant reads weight_q, so a same-cycle write only affects later grants.
            weight_d[j]   = (cfg_we && (cfg_addr == ID_W'(j))) ? cfg_wdata : weight_q[j];
        end
        pending_d     = (pending_q & ~gnt_mask_s) | spike_in;
        grant_valid_d = found_s;
        if (found_s) begin
            grant_id_d = winner_s;
            if (winner_s == ID_W'(N_INPUTS - 1)) begin
                rr_ptr_d = {ID_W{1'b0}};
            end else begin
                rr_ptr_d = winner_s + ID_W'(1);
            end
        end else begin
            grant_id_d = grant_id_q;
            rr_ptr_d   = rr_ptr_q;
        end
    end

    // Accumulate the served weight and close the timestep on the last tick cycle.
    always_comb begin
        tick_last_s = (tick_cnt_q == TICK_W'(TICK_CYCLES - 1));
        if (found_s) begin
            acc_grant_s = ACC_WIDTH'(sat_add(16'(acc_q), 16'(gnt_weight_s), ACC_WIDTH));
        end else begin
            acc_grant_s = acc_q;
        end
        if (tick_last_s) begin
            tick_cnt_d      = {TICK_W{1'b0}};
            acc_d           = {ACC_WIDTH{1'b0}};
            current_valid_d = 1'b1;
            if (acc_grant_s > CUR_MAX) begin
                current_out_d = CUR_WIDTH'(CUR_MAX);
            end else begin
                current_out_d = acc_grant_s[CUR_WIDTH-1:0];
            end
        end else begin
            tick_cnt_d      = tick_cnt_q + TICK_W'(1);
            acc_d           = acc_grant_s;
            current_valid_d = 1'b0;
            current_out_d   = current_out_q;
        end
    end

    // State registers; reset drops pending events and any partial timestep.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q       <= {N_INPUTS{1'b0}};
            rr_ptr_q        <= {ID_W{1'b0}};
            grant_id_q      <= {ID_W{1'b0}};
            grant_valid_q   <= 1'b0;
            acc_q           <= {ACC_WIDTH{1'b0}};
            tick_cnt_q      <= {TICK_W{1'b0}};
            current_out_q   <= {CUR_WIDTH{1'b0}};
            current_valid_q <= 1'b0;
            for (int j = 0; j < N_INPUTS; j++) begin
                weight_q[j] <= W_WIDTH'(default_weight(j));
            end
        end else begin
            pending_q       <= pending_d;
            rr_ptr_q        <= rr_ptr_d;
            grant_id_q      <= grant_id_d;
            grant_valid_q   <= grant_valid_d;
            acc_q           <= acc_d;
            tick_cnt_q      <= tick_cnt_d;
            current_out_q   <= current_out_d;
            current_valid_q <= current_valid_d;
            for (int j = 0; j < N_INPUTS; j++) begin
                weight_q[j] <= weight_d[j];
            end
        end
    end

    assign grant_valid   = grant_valid_q;
    assign grant_id      = grant_id_q;
    assign current_out   = current_out_q;
    assign current_valid = current_valid_q;
    assign busy          = |pending_q;

`ifdef SCHED_DROP_CNT_EN
    logic [7:0] drop_count_q, drop_count_d;
    logic [3:0] drop_num_s;
    logic [8:0] drop_sum_s;

    // A spike landing on a still-pending, ungranted input is lost.
    always_comb begin
        drop_num_s = 4'd0;
        for (int j = 0; j < N_INPUTS; j++) begin
            drop_num_s = drop_num_s + {3'b000, spike_in[j] & pending_q[j] & ~gnt_mask_s[j]};
        end
        drop_sum_s   = {1'b0, drop_count_q} + {5'b00000, drop_num_s};
        drop_count_d = drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count_q <= 8'd0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_lif_spike_scheduler.sv
// Directed self-checking bench for lif_spike_scheduler (default parameters).
module tb_lif_spike_scheduler;
    import lif_sched_pkg::*;

    logic            clk       = 1'b0;
    logic            reset     = 1'b1;
    logic [2:0]      spike_in  = 3'b000;
    logic            cfg_we    = 1'b0;
    logic [ID_W-1:0] cfg_addr  = 3'd0;
    logic [3:0]      cfg_wdata = 4'd0;
    logic            grant_valid;
    logic [ID_W-1:0] grant_id;
    logic [3:0]      current_out;
    logic            current_valid;
    logic            busy;
`ifdef SCHED_DROP_CNT_EN
    logic [7:0]      drop_count;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    lif_spike_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .spike_in      (spike_in),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .current_out   (current_out),
        .current_valid (current_valid),
        .busy          (busy)
`ifdef SCHED_DROP_CNT_EN
        ,
        .drop_count    (drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) step();
    endtask

    // Leaves the bench 1 time unit into cycle 0 with reset low.
    task automatic do_reset();
        reset     = 1'b1;
        spike_in  = 3'b000;
        cfg_we    = 1'b0;
        cfg_addr  = 3'd0;
        cfg_wdata = 4'd0;
        step();
        step();
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Test 1: reset state and single-spike latency
        do_reset();
        check("rst_gv",    32'(grant_valid),   32'd0);
        check("rst_gid",   32'(grant_id),      32'd0);
        check("rst_cur",   32'(current_out),   32'd0);
        check("rst_cv",    32'(current_valid), 32'd0);
        check("rst_busy",  32'(busy),          32'd0);
`ifdef SCHED_DROP_CNT_EN
        check("rst_drop",  32'(drop_count),    32'd0);
`endif
        step_to(2);
        spike_in = 3'b001;
        step();
        spike_in = 3'b000;
        check("t1_busy3",  32'(busy),          32'd1);
        check("t1_gv3",    32'(grant_valid),   32'd0);
        step();
        check("t1_gv4",    32'(grant_valid),   32'd1);
        check("t1_gid4",   32'(grant_id),      32'd0);
        check("t1_busy4",  32'(busy),          32'd0);
        step_to(7);
        check("t1_cv7",    32'(current_valid), 32'd0);
        step();
        check("t1_cv8",    32'(current_valid), 32'd1);
        check("t1_cur8",   32'(current_out),   32'd5);
        step();
        check("t1_cv9",    32'(current_valid), 32'd0);
        check("t1_hold9",  32'(current_out),   32'd5);

        // Test 2: three simultaneous spikes served in order
        do_reset();
        step_to(1);
        spike_in = 3'b111;
        step();
        spike_in = 3'b000;
        check("t2_busy2",  32'(busy),          32'd1);
        step();
        check("t2_gv3",    32'(grant_valid),   32'd1);
        check("t2_gid3",   32'(grant_id),      32'd0);
        step();
        check("t2_gid4",   32'(grant_id),      32'd1);
        step();
        check("t2_gid5",   32'(grant_id),      32'd2);
        step();
        check("t2_gv6",    32'(grant_valid),   32'd0);
        check("t2_hold6",  32'(grant_id),      32'd2);
        check("t2_busy6",  32'(busy),          32'd0);
        step_to(8);
        check("t2_cv8",    32'(current_valid), 32'd1);
        check("t2_cur8",   32'(current_out),   32'd12);

        // Test 3: weight rewrite and current saturation (15 + 4 -> 15)
        do_reset();
        cfg_we    = 1'b1;
        cfg_addr  = 3'd0;
        cfg_wdata = 4'd15;
        step();
        cfg_we   = 1'b0;
        spike_in = 3'b011;
        step();
        spike_in = 3'b000;
        step_to(3);
        check("t3_gid3",   32'(grant_id),      32'd0);
        step();
        check("t3_gid4",   32'(grant_id),      32'd1);
        step_to(8);
        check("t3_cv8",    32'(current_valid), 32'd1);
        check("t3_cur8",   32'(current_out),   32'd15);

        // Test 4: inputs 0 and 1 spiking continuously (cycles 0..5)
        do_reset();
        spike_in = 3'b011;
        for (int k = 0; k <= 8; k++) begin
            if (k == 6) spike_in = 3'b000;
            if (k < 2) begin
                check("t4_gv_idle", 32'(grant_valid), 32'd0);
            end else begin
                check("t4_gv",  32'(grant_valid), 32'd1);
                check("t4_gid", 32'(grant_id),    (k % 2 == 0) ? 32'd0 : 32'd1);
            end
`ifdef SCHED_DROP_CNT_EN
            check("t4_drop", 32'(drop_count), (k < 2) ? 32'd0 : ((k <= 6) ? 32'(k - 1) : 32'd5));
`endif
            if (k == 8) begin
                check("t4_cv8",  32'(current_valid), 32'd1);
                check("t4_cur8", 32'(current_out),   32'd15);
            end
            step();
        end

        // Test 5: reset mid-tick with events pending
        do_reset();
        step_to(4);
        spike_in = 3'b011;
        step();
        spike_in = 3'b000;
        check("t5_busy5",  32'(busy),          32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        cyc   = 0;
        check("t5_gv0",    32'(grant_valid),   32'd0);
        check("t5_busy0",  32'(busy),          32'd0);
        step();
        check("t5_gv1",    32'(grant_valid),   32'd0);
        check("t5_busy1",  32'(busy),          32'd0);
        step_to(7);
        check("t5_cv7",    32'(current_valid), 32'd0);
        step();
        check("t5_cv8",    32'(current_valid), 32'd1);
        check("t5_cur8",   32'(current_out),   32'd0);

        // Test 6: same-cycle weight write uses old weight; out-of-range address ignored
        do_reset();
        spike_in = 3'b010;
        step();
        spike_in  = 3'b000;
        cfg_we    = 1'b1;
        cfg_addr  = 3'd1;
        cfg_wdata = 4'd1;
        step();
        check("t6_gv2",    32'(grant_valid),   32'd1);
        check("t6_gid2",   32'(grant_id),      32'd1);
        cfg_addr  = 3'd5;
        cfg_wdata = 4'd9;
        step();
        cfg_we   = 1'b0;
        spike_in = 3'b010;
        step();
        spike_in = 3'b000;
        step();
        check("t6_gv5",    32'(grant_valid),   32'd1);
        check("t6_gid5",   32'(grant_id),      32'd1);
        step_to(8);
        check("t6_cv8",    32'(current_valid), 32'd1);
        check("t6_cur8",   32'(current_out),   32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
